imm_instr_encoder: RTL
======================

Name: imm_instr_encoder

Overview:
- Inverse of the core's immediate decoder.
- Accepts decoded instruction fields (opcode, registers, funct3/funct7, full 32-bit immediate) and packs them into a legal RV32I instruction word.
- Range-checks the immediate for the selected format.
- Emits the word with a sequential byte address through a registered valid/ready output stage, for the program loader / self-test injector that writes instruction memory.

Parameters:
- ADDR_WIDTH, 12: width of out_addr (byte address); wraps modulo 2^ADDR_WIDTH.
- BASE_ADDR, 0: out_addr value after reset or restart; must be a multiple of 4.
- NOP_WORD, 32'h00000013: word emitted for an unknown opcode.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous: drop pending output, reload address.
- in_valid  in  1  field set valid.
- in_ready  out  1  field set accepted when in_valid&in_ready.
- in_opcode  in  7  RV32I opcode.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R-type; also upper bits for SLLI/SRLI/SRAI).
- in_imm  in  32  immediate as the decoder would output it (sign-extended byte offset).
- out_valid  out  1  word valid.
- out_ready  in  1  consumer ready.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_WIDTH  byte address of out_instr.
- out_err  out  1  immediate out of range or unknown opcode, qualified by out_valid.
- err_seen  out  1  sticky OR of every transferred out_err.

Behaviour:

Reset (async, rst_n=0):
- out_valid=0, out_instr=0, out_err=0, err_seen=0, out_addr=BASE_ADDR.
- Internal next-address = BASE_ADDR.

Handshake:
- Single output register.
- in_ready = !restart && (!out_valid || out_ready).
- On accept, the encoded word is registered next edge: 1-cycle latency.
- Full throughput of one word per cycle when out_ready is held high.
- Outputs hold stable while out_valid && !out_ready.

Addressing:
- On each accept, out_addr <= next-address, then next-address += 4, wrapping modulo 2^ADDR_WIDTH.
- First word after reset has out_addr = BASE_ADDR.

Restart:
- Priority over everything: out_valid <= 0 and next-address <= BASE_ADDR.
- No input is accepted in that cycle (in_ready=0).
- err_seen is not cleared; only rst_n clears it.

Encoding (op = in_opcode, rd/rs1/rs2/f3/f7 from inputs, imm = in_imm):
- R (0110011): {f7, rs2, rs1, f3, rd, op}.
- I (0000011, 1100111, 0001111, 1110011, and 0010011 with f3 not in {001,101}): {imm[11:0], rs1, f3, rd, op}.
  - err if imm != sext(imm[11:0]).
- Shift-immediate (0010011, f3 = 001 or 101): {f7, imm[4:0], rs1, f3, rd, op}.
  - err if imm[31:5] != 0.
- S (0100011): {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - err if imm is not sign-extended from 12 bits.
- B (1100011): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - err if imm is not sign-extended from 13 bits, or imm[0]=1.
- U (0110111, 0010111): {imm[31:12], rd, op}.
  - err if imm[11:0] != 0.
- J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - err if imm is not sign-extended from 21 bits, or imm[0]=1.
- Unused fields for a format are ignored.
- Unknown opcode: out_instr = NOP_WORD, out_err=1.
- On err, the truncated encoding is still emitted and consumes an address.

err_seen:
- Set on an output transfer (out_valid && out_ready) with out_err=1.

Test Plan:
- ADDI: op=0010011, rd=1, rs1=0, f3=000, imm=5 -> out_instr=0x00500093, out_addr=0, out_err=0, one cycle after accept.
- Back-to-back, out_ready=1:
  - SW: op=0100011, rs1=1, rs2=2, f3=010, imm=8 -> 0x0020A423 @addr 0.
  - JAL: rd=1, imm=8 -> 0x008000EF @addr 4.
  - LUI: rd=5, imm=0x12345000 -> 0x123452B7 @addr 8.
- BEQ x0,x0,-4: op=1100011, imm=0xFFFFFFFC -> 0xFE000EE3.
- SRAI: rd=3, rs1=4, f3=101, f7=0100000, imm=7 -> 0x40725193.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, out_instr/out_addr stable. Then out_ready=1 -> next word follows the next cycle with addr +4.
- Errors:
  - ADDI imm=2048 -> out_err=1, err_seen=1 after transfer.
  - JAL imm=3 -> out_err=1.
  - opcode 0x7F -> out_instr=0x00000013, out_err=1.
  - restart -> out_valid=0, next out_addr=0, err_seen still 1.
  - rst_n pulse mid-backpressure -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/imm_instr_encoder_if.sv
// Field-set input and encoded-word output bundle of the immediate instruction encoder.
// The master drives fields and consumes words; the slave is the encoder.
interface imm_instr_encoder_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            in_opcode;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [31:0]           in_imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_err;
  logic                  err_seen;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_seen
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_seen
  );
endinterface

// File: rtl/imm_instr_encoder.sv
// Packs decoded RV32I fields back into an instruction word, range-checks the immediate,
// and emits it with a sequential byte address through a single registered output stage.
module imm_instr_encoder #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          BASE_ADDR  = 0,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  imm_instr_encoder_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(4);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic                  out_valid_q;
  logic [31:0]           out_instr_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic                  out_err_q;
  logic                  err_seen_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;

  logic [31:0] instr_d;
  logic        err_d;
  logic        accept;

  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic        fits12, fits13, fits21;
  logic [31:0] i_word;

  assign op  = bus.in_opcode;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign f3  = bus.in_funct3;
  assign f7  = bus.in_funct7;
  assign imm = bus.in_imm;

  // An immediate fits N signed bits when every bit from N-1 upward equals the sign bit.
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  assign i_word = {imm[11:0], rs1, f3, rd, op};

  always_comb begin
    instr_d = NOP_WORD;
    err_d   = 1'b1;
    case (op)
      OP_REG: begin
        instr_d = {f7, rs2, rs1, f3, rd, op};
        err_d   = 1'b0;
      end
      OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          instr_d = {f7, imm[4:0], rs1, f3, rd, op};
          err_d   = |imm[31:5];
        end else begin
          instr_d = i_word;
          err_d   = ~fits12;
        end
      end
      OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
        instr_d = i_word;
        err_d   = ~fits12;
      end
      OP_STORE: begin
        instr_d = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        err_d   = ~fits12;
      end
      OP_BRANCH: begin
        instr_d = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        err_d   = ~fits13 | imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        instr_d = {imm[31:12], rd, op};
        err_d   = |imm[11:0];
      end
      OP_JAL: begin
        instr_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        err_d   = ~fits21 | imm[0];
      end
      default: begin
        instr_d = NOP_WORD;
        err_d   = 1'b1;
      end
    endcase
  end

  assign bus.in_ready = ~restart & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_A;
      out_err_q   <= 1'b0;
      err_seen_q  <= 1'b0;
      next_addr_q <= BASE_A;
    end else begin
      if (out_valid_q && bus.out_ready && out_err_q) err_seen_q <= 1'b1;
      // Restart only drops the pending word and rewinds; the sticky error survives.
      if (restart) begin
        out_valid_q <= 1'b0;
        next_addr_q <= BASE_A;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        out_instr_q <= instr_d;
        out_err_q   <= err_d;
        out_addr_q  <= next_addr_q;
        next_addr_q <= next_addr_q + STEP_A;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_seen  = err_seen_q;

endmodule
